spike_window_decoder: RTL and testbench

- Downstream consumer of the perceptron neuron: samples its spike output (v_out) and membrane state (state) and reduces them to per-window statistics.
- Each window yields a spike count, a peak membrane value and an inter-spike gap minimum, offered on a valid/ready handshake.
- Feeds the readout logic that drives the chip's output pins.

---
 rtl/perceptron_pkg.sv | 25 ++
 rtl/spike_window_decoder_spike_edge_gap.sv | 93 +++++++++
 rtl/spike_window_decoder.sv | 184 ++++++++++++++++++
 tb/tb_spike_window_decoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron readout path.
// Provides default widths, the window FSM state encoding and a
// saturating increment helper used by the counters.
package perceptron_pkg;

    localparam int STATE_W_DEF = 8;
    localparam int WIN_W_DEF   = 8;
    localparam int CNT_W_DEF   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } win_state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end else begin
            return val + 32'd1;
        end
    endfunction

endpackage

// File: rtl/spike_window_decoder_spike_edge_gap.sv
// Spike edge detector plus inter-spike gap tracking for one window.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   spike_in    - raw neuron spike level
//   start       - restart gap/min-gap tracking (window start)
//   active      - window is sampling this cycle
//   spike_edge  - 0->1 transition of spike_in this cycle (combinational)
//   min_gap     - smallest distance between consecutive edges so far,
//                 all-ones until two edges have been seen
module spike_edge_gap
    import perceptron_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spike_in,
    input  logic             start,
    input  logic             active,
    output logic             spike_edge,
    output logic [WIN_W-1:0] min_gap
);

    localparam logic [WIN_W-1:0] GAP_MAX  = {WIN_W{1'b1}};
    localparam logic [WIN_W-1:0] GAP_ZERO = {WIN_W{1'b0}};

    logic             spike_prev_r;
    logic             seen_spike_r;
    logic [WIN_W-1:0] gap_r;
    logic [WIN_W-1:0] min_gap_r;
    logic             spike_edge_s;
    logic [WIN_W-1:0] gap_inc_s;
    logic [WIN_W-1:0] gap_next_s;
    logic [WIN_W-1:0] min_gap_next_s;

    assign spike_edge_s = spike_in & ~spike_prev_r;
    assign spike_edge   = spike_edge_s;
    assign min_gap      = min_gap_r;
    // gap counts cycles since the last edge minus one, so gap+1 is the distance
    assign gap_inc_s    = WIN_W'(sat_inc(32'(gap_r), 32'(GAP_MAX)));

    // Next gap and min-gap values for an active sampling cycle
    always_comb begin
        gap_next_s     = gap_r;
        min_gap_next_s = min_gap_r;
        if (spike_edge_s) begin
            gap_next_s = GAP_ZERO;
            if (seen_spike_r && (gap_inc_s < min_gap_r)) begin
                min_gap_next_s = gap_inc_s;
            end else begin
                min_gap_next_s = min_gap_r;
            end
        end else begin
            min_gap_next_s = min_gap_r;
            if (seen_spike_r) begin
                gap_next_s = gap_inc_s;
            end else begin
                gap_next_s = gap_r;
            end
        end
    end

    // Previous spike level, tracked in every state so DONE cycles still update it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spike_prev_r <= 1'b0;
        end else begin
            spike_prev_r <= spike_in;
        end
    end

    // Gap counter and min-gap tracker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_r        <= GAP_ZERO;
            min_gap_r    <= GAP_MAX;
            seen_spike_r <= 1'b0;
        end else if (start) begin
            gap_r        <= GAP_ZERO;
            min_gap_r    <= GAP_MAX;
            seen_spike_r <= 1'b0;
        end else if (active) begin
            gap_r        <= gap_next_s;
            min_gap_r    <= min_gap_next_s;
            seen_spike_r <= seen_spike_r | spike_edge_s;
        end else begin
            gap_r        <= gap_r;
            min_gap_r    <= min_gap_r;
            seen_spike_r <= seen_spike_r;
        end
    end

endmodule

// File: rtl/spike_window_decoder.sv
// Reduces the neuron spike/membrane streams to per-window statistics.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   en           - keep running windows back-to-back; 0 = stop after current
//   win_len      - window length (0 treated as 1), sampled at window start
//   spike_in     - neuron spike level; rising edge counts as a spike
//   state_in     - neuron membrane state, unsigned
//   res_*        - result on a valid/ready handshake: count, peak state,
//                  minimum inter-spike gap, overrun flag
//   busy         - window currently sampling
// A window of N cycles is followed by one DONE cycle that commits the
// result; spikes during that cycle are not counted.
module spike_window_decoder
    import perceptron_pkg::*;
#(
    parameter int WIN_W   = WIN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               spike_in,
    input  logic [STATE_W-1:0] state_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_count,
    output logic [STATE_W-1:0] res_peak,
    output logic [WIN_W-1:0]   res_min_gap,
    output logic               res_overrun,
    output logic               busy
);

    localparam logic [WIN_W-1:0]   WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]   WIN_ONE   = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0]   WIN_ONES  = {WIN_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [STATE_W-1:0] PEAK_ZERO = {STATE_W{1'b0}};

    win_state_t         state_r;
    win_state_t         next_state_s;
    logic [WIN_W-1:0]   len_r;
    logic [WIN_W-1:0]   cyc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [STATE_W-1:0] peak_r;
    logic               res_valid_r;
    logic               res_overrun_r;
    logic [CNT_W-1:0]   res_count_r;
    logic [STATE_W-1:0] res_peak_r;
    logic [WIN_W-1:0]   res_min_gap_r;
    logic               busy_r;

    logic               start_s;
    logic               commit_s;
    logic               run_s;
    logic               last_cyc_s;
    logic               accept_s;
    logic               spike_edge_s;
    logic [WIN_W-1:0]   min_gap_s;
    logic [WIN_W-1:0]   len_sel_s;
    logic [CNT_W-1:0]   cnt_inc_s;

    assign last_cyc_s = (cyc_r == (len_r - WIN_ONE));
    assign accept_s   = res_valid_r & res_ready;
    assign len_sel_s  = (win_len == WIN_ZERO) ? WIN_ONE : win_len;
    assign cnt_inc_s  = CNT_W'(sat_inc(32'(cnt_r), 32'(CNT_MAX)));

    spike_edge_gap #(
        .WIN_W (WIN_W)
    ) u_edge_gap (
        .clk        (clk),
        .reset      (reset),
        .spike_in   (spike_in),
        .start      (start_s),
        .active     (run_s),
        .spike_edge (spike_edge_s),
        .min_gap    (min_gap_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: next_state_s = en ? ST_RUN : ST_IDLE;
            ST_RUN:  next_state_s = last_cyc_s ? ST_DONE : ST_RUN;
            ST_DONE: next_state_s = en ? ST_RUN : ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM decoded controls; start fires on the edge that enters RUN
    always_comb begin
        run_s    = (state_r == ST_RUN);
        commit_s = (state_r == ST_DONE);
        if ((state_r != ST_RUN) && (next_state_s == ST_RUN)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
    end

    // Window length latch, cycle counter, spike count and peak tracker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r  <= WIN_ONE;
            cyc_r  <= WIN_ZERO;
            cnt_r  <= CNT_ZERO;
            peak_r <= PEAK_ZERO;
        end else if (start_s) begin
            len_r  <= len_sel_s;
            cyc_r  <= WIN_ZERO;
            cnt_r  <= CNT_ZERO;
            peak_r <= PEAK_ZERO;
        end else if (run_s) begin
            len_r  <= len_r;
            cyc_r  <= cyc_r + WIN_ONE;
            cnt_r  <= spike_edge_s ? cnt_inc_s : cnt_r;
            peak_r <= (state_in > peak_r) ? state_in : peak_r;
        end else begin
            len_r  <= len_r;
            cyc_r  <= cyc_r;
            cnt_r  <= cnt_r;
            peak_r <= peak_r;
        end
    end

    // Result registers and valid/ready handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_r   <= 1'b0;
            res_overrun_r <= 1'b0;
            res_count_r   <= CNT_ZERO;
            res_peak_r    <= PEAK_ZERO;
            res_min_gap_r <= WIN_ONES;
        end else if (commit_s) begin
            // an unaccepted result being replaced is an overrun; a same-cycle accept is not
            res_valid_r   <= 1'b1;
            res_overrun_r <= res_valid_r & ~res_ready;
            res_count_r   <= cnt_r;
            res_peak_r    <= peak_r;
            res_min_gap_r <= min_gap_s;
        end else if (accept_s) begin
            res_valid_r   <= 1'b0;
            res_overrun_r <= 1'b0;
            res_count_r   <= res_count_r;
            res_peak_r    <= res_peak_r;
            res_min_gap_r <= res_min_gap_r;
        end else begin
            res_valid_r   <= res_valid_r;
            res_overrun_r <= res_overrun_r;
            res_count_r   <= res_count_r;
            res_peak_r    <= res_peak_r;
            res_min_gap_r <= res_min_gap_r;
        end
    end

    // Busy flag registered from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_RUN);
        end
    end

    assign res_valid   = res_valid_r;
    assign res_overrun = res_overrun_r;
    assign res_count   = res_count_r;
    assign res_peak    = res_peak_r;
    assign res_min_gap = res_min_gap_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Self-checking bench for spike_window_decoder: vector table of single
// windows, hand-written overrun and reset sequences, and randomized
// back-to-back windows checked against a window-level reference model.
module tb_spike_window_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] win_len;
    logic       spike_in;
    logic [7:0] state_in;
    logic       res_valid;
    logic       res_ready;
    logic [5:0] res_count;
    logic [7:0] res_peak;
    logic [7:0] res_min_gap;
    logic       res_overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    spike_window_decoder #(
        .WIN_W   (8),
        .CNT_W   (6),
        .STATE_W (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .win_len     (win_len),
        .spike_in    (spike_in),
        .state_in    (state_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_peak    (res_peak),
        .res_min_gap (res_min_gap),
        .res_overrun (res_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   len;
        logic [255:0] sp;
        int           cnt;
        int           peak;
        int           gap;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs set before calling are sampled by the posedge,
    // outputs are read at the following negedge.
    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; en = 1'b0; spike_in = 1'b0; state_in = 8'd0;
        res_ready = 1'b0; win_len = 8'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_count"}, res_count, 0);
        chk({tag, "_peak"}, res_peak, 0);
        chk({tag, "_gap"}, res_min_gap, 255);
        chk({tag, "_ovr"}, res_overrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Single window from IDLE; state_in ramps with the window cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int le;
        le = (v.len == 8'd0) ? 1 : int'(v.len);
        do_reset();
        win_len = v.len; en = 1'b1; res_ready = 1'b1; spike_in = 1'b0; state_in = 8'd0;
        tick();
        chk($sformatf("v%0d_busy", idx), busy, 1);
        for (int i = 0; i < le; i++) begin
            spike_in = v.sp[i];
            state_in = 8'(i);
            tick();
        end
        chk($sformatf("v%0d_valid_early", idx), res_valid, 0);
        // DONE cycle: a rising spike and a large state here must be ignored
        en = 1'b0; spike_in = 1'b1; state_in = 8'hFF;
        tick();
        chk($sformatf("v%0d_valid", idx), res_valid, 1);
        chk($sformatf("v%0d_count", idx), res_count, v.cnt);
        chk($sformatf("v%0d_peak", idx), res_peak, v.peak);
        chk($sformatf("v%0d_gap", idx), res_min_gap, v.gap);
        chk($sformatf("v%0d_ovr", idx), res_overrun, 0);
        spike_in = 1'b0; state_in = 8'd0;
        tick();
        chk($sformatf("v%0d_accepted", idx), res_valid, 0);
    endtask

    // Back-to-back random windows with en held high and random res_ready.
    task automatic rand_phase(input int L, input int n);
        int  le;
        bit  sp[600];
        int  st[600];
        bit  valid_m, ovr_m, acc;
        int  cnt_m, peak_m, gap_m, last, c, pk, mg, s, e;
        le = (L == 0) ? 1 : L;
        valid_m = 1'b0; ovr_m = 1'b0; cnt_m = 0; peak_m = 0; gap_m = 255;
        do_reset();
        win_len = 8'(L); en = 1'b1;
        for (int p = 0; p < n; p++) begin
            spike_in  = ($urandom_range(0, 2) == 0);
            state_in  = 8'($urandom_range(0, 200));
            res_ready = ($urandom_range(0, 1) == 1);
            sp[p] = spike_in;
            st[p] = int'(state_in);
            acc = valid_m & res_ready;
            tick();
            if (p >= 1 && (p % (le + 1)) == 0) begin
                s = p - le; e = p - 1;
                c = 0; pk = 0; mg = 255; last = -1;
                for (int q = s; q <= e; q++) begin
                    if (st[q] > pk) pk = st[q];
                    if (sp[q] && !sp[q-1]) begin
                        c++;
                        if (last >= 0 && (q - last) < mg) mg = q - last;
                        last = q;
                    end
                end
                cnt_m = (c > 63) ? 63 : c;
                peak_m = pk; gap_m = mg;
                ovr_m = valid_m & ~acc;
                valid_m = 1'b1;
            end else if (acc) begin
                valid_m = 1'b0; ovr_m = 1'b0;
            end
            chk("rnd_valid", res_valid, int'(valid_m));
            chk("rnd_ovr", res_overrun, int'(ovr_m));
            chk("rnd_busy", busy, (((p + 1) % (le + 1)) != 0) ? 1 : 0);
            if (valid_m) begin
                chk("rnd_count", res_count, cnt_m);
                chk("rnd_peak", res_peak, peak_m);
                chk("rnd_gap", res_min_gap, gap_m);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Vector table
        vecs[0].len = 8'd10; vecs[0].sp = 256'd0;
        vecs[0].sp[2] = 1'b1; vecs[0].sp[5] = 1'b1; vecs[0].sp[9] = 1'b1;
        vecs[0].cnt = 3; vecs[0].peak = 9; vecs[0].gap = 3;
        vecs[1].len = 8'd8; vecs[1].sp = 256'd0;
        for (int i = 0; i < 8; i++) vecs[1].sp[i] = 1'b1;
        vecs[1].cnt = 1; vecs[1].peak = 7; vecs[1].gap = 255;
        vecs[2].len = 8'd0; vecs[2].sp = 256'd0; vecs[2].sp[0] = 1'b1;
        vecs[2].cnt = 1; vecs[2].peak = 0; vecs[2].gap = 255;
        vecs[3].len = 8'd150; vecs[3].sp = 256'd0;
        for (int i = 0; i < 140; i += 2) vecs[3].sp[i] = 1'b1;
        vecs[3].cnt = 63; vecs[3].peak = 149; vecs[3].gap = 2;
        vecs[4].len = 8'd6; vecs[4].sp = 256'd0;
        vecs[4].sp[0] = 1'b1; vecs[4].sp[2] = 1'b1; vecs[4].sp[3] = 1'b1;
        vecs[4].cnt = 2; vecs[4].peak = 5; vecs[4].gap = 2;
        vecs[5].len = 8'd5; vecs[5].sp = 256'd0;
        vecs[5].cnt = 0; vecs[5].peak = 4; vecs[5].gap = 255;

        // Reset state
        reset = 1'b1; en = 1'b0; spike_in = 1'b0; state_in = 8'd0;
        res_ready = 1'b0; win_len = 8'd0;
        #1;
        chk_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

        // Three windows with no consumer: overrun after the second
        do_reset();
        win_len = 8'd4; en = 1'b1; res_ready = 1'b0; spike_in = 1'b0; state_in = 8'd0;
        tick();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                spike_in = (i == k);
                state_in = 8'(k * 10 + i);
                tick();
                if (k >= 1 && i == 1) chk("ovr_hold_peak", res_peak, (k - 1) * 10 + 3);
            end
            if (k == 2) en = 1'b0;
            spike_in = 1'b0; state_in = 8'd0;
            tick();
            chk("ovr_valid", res_valid, 1);
            chk("ovr_flag", res_overrun, (k >= 1) ? 1 : 0);
            chk("ovr_peak", res_peak, k * 10 + 3);
            chk("ovr_count", res_count, 1);
        end
        tick();
        chk("ovr_stable_peak", res_peak, 23);
        chk("ovr_stable_flag", res_overrun, 1);
        res_ready = 1'b1;
        tick();
        chk("ovr_accept_valid", res_valid, 0);
        chk("ovr_accept_flag", res_overrun, 0);

        // Reset in the middle of a window after a pending result
        do_reset();
        win_len = 8'd10; en = 1'b1; res_ready = 1'b0; spike_in = 1'b0; state_in = 8'd0;
        tick();
        for (int i = 0; i < 10; i++) begin
            spike_in = (i == 3); state_in = 8'(i + 20);
            tick();
        end
        spike_in = 1'b0; state_in = 8'd0;
        tick();
        chk("mid_pre_valid", res_valid, 1);
        chk("mid_pre_count", res_count, 1);
        for (int i = 0; i < 5; i++) begin
            spike_in = (i == 1); state_in = 8'd50;
            tick();
        end
        reset = 1'b1;
        #1;
        chk_cleared("mid_reset");
        @(negedge clk);
        reset = 1'b0; en = 1'b0; spike_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mid_idle_valid", res_valid, 0);
        end
        win_len = 8'd2; en = 1'b1;
        tick();
        spike_in = 1'b1; state_in = 8'd7;
        tick();
        en = 1'b0; spike_in = 1'b0; state_in = 8'd3;
        tick();
        chk("mid_fresh_early", res_valid, 0);
        tick();
        chk("mid_fresh_valid", res_valid, 1);
        chk("mid_fresh_count", res_count, 1);
        chk("mid_fresh_peak", res_peak, 7);

        // Randomized back-to-back windows
        rand_phase(0, 60);
        rand_phase(1, 60);
        rand_phase(3, 80);
        rand_phase(7, 100);
        rand_phase(12, 120);
        rand_phase($urandom_range(2, 9), 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
